relay_sequencer: RTL and testbench

- Downstream consumer of the relay clock circuit's `clock` pulse train.
- Converts each rising edge of that pulse into one step of the instruction sequencer (steps 1..NUM_STEPS).
- Outputs a one-hot step vector and a binary step number for the control decoder, plus a fetch-phase flag and an end-of-instruction pulse.
- The decoder supplies an abort code that sets the instruction length, so short instructions wrap early.

---
 rtl/relay_pkg.sv | 28 ++
 rtl/relay_pulse_edge.sv | 22 ++
 rtl/relay_sequencer.sv | 70 +++++++
 tb/tb_relay_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared definitions for the relay instruction sequencer: abort codes and
// the mapping from abort code to instruction length in steps.
package relay_pkg;

   typedef logic [2:0] abort_code_t;

   localparam abort_code_t ABORT_NONE = 3'd0;
   localparam abort_code_t ABORT_8    = 3'd1;
   localparam abort_code_t ABORT_10   = 3'd2;
   localparam abort_code_t ABORT_12   = 3'd3;
   localparam abort_code_t ABORT_14   = 3'd4;

   // Reserved codes fall back to the full instruction length; short limits
   // are clamped so a small max_steps can never be overrun.
   function automatic int unsigned abort_limit(abort_code_t code, int unsigned max_steps = 24);
      int unsigned lim;
      case (code)
         ABORT_8:  lim = 8;
         ABORT_10: lim = 10;
         ABORT_12: lim = 12;
         ABORT_14: lim = 14;
         default:  lim = max_steps;
      endcase
      if (lim > max_steps) lim = max_steps;
      return lim;
   endfunction

endpackage

// File: rtl/relay_pulse_edge.sv
// Single-bit rising-edge detector with a gating enable, for consumers of
// the relay clock pulse train.
module relay_pulse_edge (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic rise
);

   logic d_q;

   // d_q follows d even while disabled, so a level already high when the
   // enable returns is not mistaken for a new edge.
   always_ff @(posedge clock) begin
      if (reset) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign rise = en & d & ~d_q;

endmodule

// File: rtl/relay_sequencer.sv
// Instruction step sequencer: one step per relay clock pulse edge, wrapping
// at the length selected by the decoder's abort code.
module relay_sequencer
   import relay_pkg::*;
#(
   parameter int NUM_STEPS   = 24,
   parameter int FETCH_STEPS = 8,
   parameter int STEP_W      = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 power,
   input  logic                 clock_pulse,
   input  abort_code_t          abort_code,
   output logic [NUM_STEPS-1:0] step_onehot,
   output logic [STEP_W-1:0]    step_num,
   output logic                 fetch_phase,
   output logic                 instr_done
);

   localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
   localparam logic [STEP_W-1:0] FETCH_LAST = STEP_W'(FETCH_STEPS);

   logic              advance;
   logic [STEP_W-1:0] limit;
   logic [STEP_W-1:0] next_step;
   logic              next_done;

   relay_pulse_edge u_edge (
      .clock (clock),
      .reset (reset),
      .en    (power),
      .d     (clock_pulse),
      .rise  (advance)
   );

   assign limit = STEP_W'(abort_limit(abort_code, NUM_STEPS));

   // >= rather than == so a limit lowered mid-instruction wraps immediately.
   always_comb begin
      next_step = step_num;
      next_done = 1'b0;
      if (!power) begin
         next_step = STEP_ONE;
      end else if (advance) begin
         if (step_num >= limit) begin
            next_step = STEP_ONE;
            next_done = 1'b1;
         end else begin
            next_step = step_num + STEP_ONE;
         end
      end
   end

   // All outputs derive from next_step in the same edge so they never disagree.
   always_ff @(posedge clock) begin
      if (reset) begin
         step_num    <= STEP_ONE;
         step_onehot <= NUM_STEPS'(1);
         fetch_phase <= 1'b1;
         instr_done  <= 1'b0;
      end else begin
         step_num    <= next_step;
         step_onehot <= NUM_STEPS'(1) << (next_step - STEP_ONE);
         fetch_phase <= (next_step <= FETCH_LAST);
         instr_done  <= next_done;
      end
   end

endmodule

// File: tb/tb_relay_sequencer.sv
// Scoreboard bench for relay_sequencer: a cycle model pushes expected
// outputs on every drive; a monitor pops and compares after each edge.
module tb_relay_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        power = 1'b0;
   logic        clock_pulse = 1'b0;
   logic [2:0]  abort_code = 3'd0;
   logic [23:0] step_onehot;
   logic [4:0]  step_num;
   logic        fetch_phase;
   logic        instr_done;

   relay_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .power       (power),
      .clock_pulse (clock_pulse),
      .abort_code  (abort_code),
      .step_onehot (step_onehot),
      .step_num    (step_num),
      .fetch_phase (fetch_phase),
      .instr_done  (instr_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  step;
      logic [23:0] oh;
      logic        fetch;
      logic        done;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   m_step = 1;
   bit   m_pq = 1'b0;
   bit   m_done = 1'b0;

   function automatic int ref_limit(logic [2:0] code);
      case (code)
         3'd1: return 8;
         3'd2: return 10;
         3'd3: return 12;
         3'd4: return 14;
         default: return 24;
      endcase
   endfunction

   // Drive one cycle of inputs, advance the model, push the expectation,
   // and return just after the edge so tasks can inspect the result.
   task automatic drive(input bit rst, input bit pwr, input bit pls, input logic [2:0] code);
      exp_t e;
      logic [23:0] one;
      bit adv;
      @(negedge clock);
      reset = rst; power = pwr; clock_pulse = pls; abort_code = code;
      if (rst) begin
         m_step = 1; m_pq = 1'b0; m_done = 1'b0;
      end else begin
         adv = pwr && pls && !m_pq;
         m_pq = pls;
         m_done = 1'b0;
         if (!pwr) m_step = 1;
         else if (adv) begin
            if (m_step >= ref_limit(code)) begin
               m_step = 1; m_done = 1'b1;
            end else m_step = m_step + 1;
         end
      end
      one = 24'd1;
      e.step  = 5'(m_step);
      e.oh    = one << (m_step - 1);
      e.fetch = (m_step <= 8);
      e.done  = m_done;
      q.push_back(e);
      @(posedge clock);
      #2;
   endtask

   task automatic pulse(input logic [2:0] code);
      drive(0, 1, 1, code);
      repeat (3) drive(0, 1, 0, code);
   endtask

   always @(posedge clock) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (instr_done === 1'b1) done_seen++;
         checks++;
         if (step_num !== e.step) begin
            errors++; $display("FAIL step_num t=%0t got %0d exp %0d", $time, step_num, e.step);
         end
         checks++;
         if (step_onehot !== e.oh) begin
            errors++; $display("FAIL step_onehot t=%0t got %h exp %h", $time, step_onehot, e.oh);
         end
         checks++;
         if (fetch_phase !== e.fetch) begin
            errors++; $display("FAIL fetch_phase t=%0t got %b exp %b", $time, fetch_phase, e.fetch);
         end
         checks++;
         if (instr_done !== e.done) begin
            errors++; $display("FAIL instr_done t=%0t got %b exp %b", $time, instr_done, e.done);
         end
      end
   end

   task automatic test_reset();
      drive(1, 1, 1, 3'd0);
      drive(1, 1, 1, 3'd0);
      checks++;
      if (step_num !== 5'd1 || instr_done !== 1'b0 || step_onehot !== 24'd1 || fetch_phase !== 1'b1) begin
         errors++; $display("FAIL reset_state got step=%0d done=%b oh=%h fetch=%b exp 1/0/000001/1",
                            step_num, instr_done, step_onehot, fetch_phase);
      end
      drive(1, 1, 0, 3'd0);
      drive(0, 1, 0, 3'd0);
   endtask

   task automatic test_fetch8();
      done_seen = 0;
      for (int i = 0; i < 8; i++) pulse(3'd1);
      checks++;
      if (done_seen !== 1) begin
         errors++; $display("FAIL fetch8_done_count got %0d exp 1", done_seen);
      end
      checks++;
      if (step_num !== 5'd1) begin
         errors++; $display("FAIL fetch8_final_step got %0d exp 1", step_num);
      end
   endtask

   task automatic test_full24();
      done_seen = 0;
      for (int i = 0; i < 23; i++) pulse(3'd0);
      checks++;
      if (step_num !== 5'd24 || fetch_phase !== 1'b0) begin
         errors++; $display("FAIL full24_top got step=%0d fetch=%b exp 24/0", step_num, fetch_phase);
      end
      drive(0, 1, 1, 3'd0);
      checks++;
      if (step_num !== 5'd1 || instr_done !== 1'b1) begin
         errors++; $display("FAIL full24_wrap got step=%0d done=%b exp 1/1", step_num, instr_done);
      end
      repeat (3) drive(0, 1, 0, 3'd0);
      checks++;
      if (done_seen !== 1) begin
         errors++; $display("FAIL full24_done_count got %0d exp 1", done_seen);
      end
   endtask

   task automatic test_held();
      repeat (10) drive(0, 1, 1, 3'd0);
      drive(0, 1, 0, 3'd0);
      checks++;
      if (step_num !== 5'd2) begin
         errors++; $display("FAIL held_pulse got step=%0d exp 2", step_num);
      end
   endtask

   task automatic test_abort_change();
      for (int i = 0; i < 10; i++) pulse(3'd0);
      checks++;
      if (step_num !== 5'd12) begin
         errors++; $display("FAIL abort_pre got step=%0d exp 12", step_num);
      end
      drive(0, 1, 1, 3'd1);
      checks++;
      if (step_num !== 5'd1 || instr_done !== 1'b1) begin
         errors++; $display("FAIL abort_shrink got step=%0d done=%b exp 1/1", step_num, instr_done);
      end
      drive(0, 1, 0, 3'd1);
      checks++;
      if (instr_done !== 1'b0) begin
         errors++; $display("FAIL abort_done_width got done=%b exp 0", instr_done);
      end
   endtask

   task automatic test_power();
      for (int i = 0; i < 4; i++) pulse(3'd0);
      drive(0, 0, 0, 3'd0);
      checks++;
      if (step_num !== 5'd1) begin
         errors++; $display("FAIL power_off got step=%0d exp 1", step_num);
      end
      drive(0, 0, 1, 3'd0);
      drive(0, 1, 1, 3'd0);
      drive(0, 1, 1, 3'd0);
      checks++;
      if (step_num !== 5'd1) begin
         errors++; $display("FAIL power_return_high got step=%0d exp 1", step_num);
      end
      drive(0, 1, 0, 3'd0);
      drive(0, 1, 1, 3'd0);
      checks++;
      if (step_num !== 5'd2) begin
         errors++; $display("FAIL power_new_edge got step=%0d exp 2", step_num);
      end
      drive(0, 1, 0, 3'd0);
      drive(0, 0, 1, 3'd0);
      checks++;
      if (step_num !== 5'd1 || instr_done !== 1'b0) begin
         errors++; $display("FAIL power_vs_edge got step=%0d done=%b exp 1/0", step_num, instr_done);
      end
      drive(0, 1, 0, 3'd0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) pulse(3'd0);
      checks++;
      if (step_num !== 5'd7) begin
         errors++; $display("FAIL reset_mid_pre got step=%0d exp 7", step_num);
      end
      drive(1, 1, 1, 3'd0);
      checks++;
      if (step_num !== 5'd1 || instr_done !== 1'b0) begin
         errors++; $display("FAIL reset_mid got step=%0d done=%b exp 1/0", step_num, instr_done);
      end
      drive(1, 1, 1, 3'd0);
      drive(1, 1, 0, 3'd0);
      drive(0, 1, 0, 3'd0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) != 0),
               ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
      drive(1, 1, 0, 3'd0);
      drive(0, 1, 0, 3'd0);
   endtask

   initial begin
      test_reset();
      test_fetch8();
      test_full24();
      test_held();
      test_abort_change();
      test_power();
      test_reset_mid();
      test_random();
      repeat (2) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
